peripheral_bus: RTL

- Memory-mapped peripheral responder on the CPU data-memory port (MEM stage); the CPU's load/store path is the initiator, this block is the responder.
- Sits beside DataMemory and sees the same MemRead / MemWrite / address / write_data.
- Provides a reloadable interval timer with interrupt, an LED output register and a free-running system tick counter.
- The CPU selects read_data from this block when hit is high.

---
 rtl/peripheral_bus.sv | 104 ++++++++++
 1 files changed

// File: rtl/peripheral_bus.sv
// Memory-mapped timer / LED / systick responder on the CPU data-memory port.
// Reads are combinational; writes commit at the posedge where MemWrite && hit.
module peripheral_bus #(
   parameter logic [31:0] BASE_ADDR = 32'h40000000,
   parameter int          LED_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 MemRead,
   input  logic                 MemWrite,
   input  logic [31:0]          address,
   input  logic [31:0]          write_data,
   output logic [31:0]          read_data,
   output logic                 hit,
   output logic                 irq,
   output logic [LED_WIDTH-1:0] leds
);

   localparam logic [2:0] REG_TH   = 3'd0;
   localparam logic [2:0] REG_TL   = 3'd1;
   localparam logic [2:0] REG_TCON = 3'd2;
   localparam logic [2:0] REG_LED  = 3'd3;
   localparam logic [2:0] REG_TICK = 3'd5;

   logic [31:0]          th_q, th_d;
   logic [31:0]          tl_q, tl_d;
   logic [2:0]           tcon_q, tcon_d;
   logic [LED_WIDTH-1:0] led_q, led_d;
   logic [31:0]          systick_q, systick_d;

   logic [29:0] widx;
   logic [2:0]  sel;
   logic        wr;
   logic        ovf;
   logic        irq_set;
   logic        unused_addr_lsb;

   // Word index relative to the window; addresses below BASE wrap to large values and miss.
   assign widx            = address[31:2] - BASE_ADDR[31:2];
   assign hit             = (widx <= 30'd5);
   assign sel             = widx[2:0];
   assign wr              = MemWrite && hit;
   assign unused_addr_lsb = ^address[1:0];

   assign ovf     = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
   assign irq_set = ovf && tcon_q[1];

   always_comb begin
      read_data = 32'h0;
      if (MemRead && hit) begin
         case (sel)
            REG_TH:   read_data = th_q;
            REG_TL:   read_data = tl_q;
            REG_TCON: read_data = {29'h0, tcon_q};
            REG_LED:  read_data = 32'(led_q);
            REG_TICK: read_data = systick_q;
            default:  read_data = 32'h0;
         endcase
      end
   end

   always_comb begin
      th_d      = th_q;
      tl_d      = tl_q;
      tcon_d    = {tcon_q[2] | irq_set, tcon_q[1:0]};
      led_d     = led_q;
      systick_d = systick_q + 32'd1;

      if (tcon_q[0]) begin
         tl_d = ovf ? th_q : tl_q + 32'd1;
      end

      // CPU writes override hardware updates, except a pending irq set is never dropped.
      if (wr) begin
         case (sel)
            REG_TH:   th_d   = write_data;
            REG_TL:   tl_d   = write_data;
            REG_TCON: tcon_d = {write_data[2] | irq_set, write_data[1:0]};
            REG_LED:  led_d  = write_data[LED_WIDTH-1:0];
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         th_q      <= 32'h0;
         tl_q      <= 32'h0;
         tcon_q    <= 3'h0;
         led_q     <= '0;
         systick_q <= 32'h0;
      end else begin
         th_q      <= th_d;
         tl_q      <= tl_d;
         tcon_q    <= tcon_d;
         led_q     <= led_d;
         systick_q <= systick_d;
      end
   end

   assign irq  = tcon_q[2];
   assign leds = led_q;

endmodule
